sram_access_sequencer: RTL

SRAM_ACCESS_SEQUENCER -- requirements
Module: sram_access_sequencer

---
 rtl/sram_access_sequencer_pkg.sv | 23 ++
 rtl/sram_access_sequencer_phase_timer.sv | 66 ++++++
 rtl/sram_access_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_access_sequencer_pkg
// Description : Shared default widths and FSM state encoding for the
//               SRAM access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_access_sequencer_pkg;

  localparam int unsigned C_ADDR_W   = 9;
  localparam int unsigned C_DATA_W   = 8;
  localparam int unsigned C_FACTOR_W = 8;
  localparam int unsigned C_BURST_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_NEXT = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/sram_access_sequencer_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : sram_phase_timer
// Description : Per-beat phase counter with the held effective factor and
//               the decoded phase strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_phase_timer
  import sram_access_sequencer_pkg::*;
#(
  parameter int unsigned FACTOR_W = C_FACTOR_W
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                load_i,
  input  logic                restart_i,
  input  logic                run_i,
  input  logic [FACTOR_W-1:0] factor_i,
  output logic                at_zero_o,
  output logic                at_one_o,
  output logic                at_half_o,
  output logic                at_last_o,
  output logic                at_end_o
);

  // Three extra bits so that 4*Fe never overflows the counter.
  localparam int unsigned CNT_W = FACTOR_W + 3;

  logic [FACTOR_W-1:0] fe_q, fe_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    half_w, end_w;

  assign half_w = {2'b00, fe_q, 1'b0};
  assign end_w  = {1'b0, fe_q, 2'b00};

  always_comb begin
    fe_d  = fe_q;
    cnt_d = cnt_q;
    if (load_i) begin
      fe_d  = (factor_i == '0) ? FACTOR_W'(1) : factor_i;
      cnt_d = '0;
    end else if (restart_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      fe_q  <= FACTOR_W'(1);
      cnt_q <= '0;
    end else begin
      fe_q  <= fe_d;
      cnt_q <= cnt_d;
    end
  end

  assign at_zero_o = (cnt_q == '0);
  assign at_one_o  = (cnt_q == CNT_W'(1));
  assign at_half_o = (cnt_q == half_w);
  assign at_last_o = (cnt_q == end_w - CNT_W'(1));
  assign at_end_o  = (cnt_q == end_w);

endmodule
`default_nettype wire

// File: rtl/sram_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sram_access_sequencer
// Description : Burst read/write sequencer generating SRAM clock, enables,
//               address and data with a programmable beat length.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_access_sequencer
  import sram_access_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = C_ADDR_W,
  parameter int unsigned DATA_W   = C_DATA_W,
  parameter int unsigned FACTOR_W = C_FACTOR_W,
  parameter int unsigned BURST_W  = C_BURST_W
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic [FACTOR_W-1:0] clk_factor,
  input  logic                start_in,
  input  logic                rw_in,
  input  logic [BURST_W-1:0]  burst_len_in,
  input  logic                abort_in,
  input  logic [ADDR_W-1:0]   a_in,
  input  logic [DATA_W-1:0]   d_in,
  input  logic [DATA_W-1:0]   q_in,
  output logic                clk_out,
  output logic                cen_out,
  output logic                wen_out,
  output logic [ADDR_W-1:0]   a_out,
  output logic [DATA_W-1:0]   d_out,
  output logic [DATA_W-1:0]   q_out,
  output logic                q_valid,
  output logic                d_take,
  output logic                busy,
  output logic                done
);

  seq_state_e state_q, state_d;

  logic                start_q, rw_in_q, abort_q;
  logic [BURST_W-1:0]  blen_q;
  logic [ADDR_W-1:0]   a_in_q;

  logic                rw_q, rw_d, abt_pend_q, abt_pend_d;
  logic [BURST_W-1:0]  beats_q, beats_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, a_out_q, a_out_d;
  logic [DATA_W-1:0]   d_out_q, d_out_d, q_out_q, q_out_d;
  logic                clk_q, clk_d, cen_q, cen_d, wen_q, wen_d;
  logic                qv_q, qv_d, dt_q, dt_d, busy_q, busy_d, done_q, done_d;

  logic t_load, t_restart, t_run;
  logic t_zero, t_one, t_half, t_last, t_end;

  sram_phase_timer #(.FACTOR_W(FACTOR_W)) u_timer (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .load_i    (t_load),
    .restart_i (t_restart),
    .run_i     (t_run),
    .factor_i  (clk_factor),
    .at_zero_o (t_zero),
    .at_one_o  (t_one),
    .at_half_o (t_half),
    .at_last_o (t_last),
    .at_end_o  (t_end)
  );

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    beats_d    = beats_q;
    addr_d     = addr_q;
    abt_pend_d = abt_pend_q | ((state_q != ST_IDLE) & abort_q);
    clk_d      = clk_q;
    cen_d      = cen_q;
    wen_d      = wen_q;
    a_out_d    = a_out_q;
    d_out_d    = d_out_q;
    q_out_d    = q_out_q;
    busy_d     = busy_q;
    qv_d       = 1'b0;
    dt_d       = 1'b0;
    done_d     = 1'b0;
    t_load     = 1'b0;
    t_restart  = 1'b0;
    t_run      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A start arriving together with an abort yields a single-beat burst.
        abt_pend_d = 1'b0;
        if (start_q) begin
          state_d    = ST_LOW;
          busy_d     = 1'b1;
          rw_d       = rw_in_q;
          beats_d    = blen_q;
          addr_d     = a_in_q;
          abt_pend_d = abort_q;
          t_load     = 1'b1;
        end
      end
      ST_LOW, ST_HIGH: begin
        t_run = 1'b1;
        if (t_zero) clk_d = 1'b0;
        if (t_one) begin
          cen_d   = 1'b0;
          a_out_d = addr_q;
          if (!rw_q) begin
            wen_d   = 1'b0;
            d_out_d = d_in;
            dt_d    = 1'b1;
          end
        end
        if (t_half) begin
          state_d = ST_HIGH;
          clk_d   = 1'b1;
        end
        if (t_last) begin
          if (rw_q) begin
            q_out_d = q_in;
            qv_d    = 1'b1;
          end
          cen_d   = 1'b1;
          wen_d   = 1'b1;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (t_end) begin
          if ((beats_q != '0) && !abt_pend_d) begin
            addr_d    = addr_q + ADDR_W'(1);
            beats_d   = beats_q - BURST_W'(1);
            t_restart = 1'b1;
            state_d   = ST_LOW;
          end else begin
            state_d    = ST_IDLE;
            clk_d      = 1'b1;
            cen_d      = 1'b1;
            wen_d      = 1'b1;
            a_out_d    = '1;
            d_out_d    = '1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            abt_pend_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      start_q    <= 1'b0;
      rw_in_q    <= 1'b0;
      abort_q    <= 1'b0;
      blen_q     <= '0;
      a_in_q     <= '0;
      state_q    <= ST_IDLE;
      rw_q       <= 1'b0;
      beats_q    <= '0;
      addr_q     <= '0;
      abt_pend_q <= 1'b0;
      clk_q      <= 1'b1;
      cen_q      <= 1'b1;
      wen_q      <= 1'b1;
      a_out_q    <= '1;
      d_out_q    <= '1;
      q_out_q    <= '0;
      qv_q       <= 1'b0;
      dt_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      start_q    <= start_in;
      rw_in_q    <= rw_in;
      abort_q    <= abort_in;
      blen_q     <= burst_len_in;
      a_in_q     <= a_in;
      state_q    <= state_d;
      rw_q       <= rw_d;
      beats_q    <= beats_d;
      addr_q     <= addr_d;
      abt_pend_q <= abt_pend_d;
      clk_q      <= clk_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      a_out_q    <= a_out_d;
      d_out_q    <= d_out_d;
      q_out_q    <= q_out_d;
      qv_q       <= qv_d;
      dt_q       <= dt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign clk_out = clk_q;
  assign cen_out = cen_q;
  assign wen_out = wen_q;
  assign a_out   = a_out_q;
  assign d_out   = d_out_q;
  assign q_out   = q_out_q;
  assign q_valid = qv_q;
  assign d_take  = dt_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire
